// File: rtl/assoc_cache_control_pkg.sv
`default_nettype none
// ============================================================================
// cache_types : controller state encoding and one-hot way helper
// Rev 1.0
// ============================================================================
package cache_types;

  localparam int MAX_WAYS = 8;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_TAG_CHECK  = 2'd1,
    ST_WRITE_BACK = 2'd2,
    ST_ALLOCATE   = 2'd3
  } cache_state_t;

  // Callers narrow the result to their own WAYS with a cast.
  function automatic logic [MAX_WAYS-1:0] way_onehot(input logic [2:0] idx);
    logic [MAX_WAYS-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage
`default_nettype wire

// File: rtl/assoc_cache_control_if.sv
`default_nettype none
// ============================================================================
// assoc_cache_control_if : CPU/datapath/pmem bundle for assoc_cache_control
// Rev 1.0
// ============================================================================
interface assoc_cache_control_if #(
  parameter int WAYS  = 2,
  parameter int CNT_W = 32
);
  localparam int IW = $clog2(WAYS);

  logic            mem_read;
  logic            mem_write;
  logic [WAYS-1:0] hit;
  logic [WAYS-1:0] valid;
  logic [WAYS-1:0] dirty;
  logic [IW-1:0]   lru_way;
  logic            pmem_resp;

  logic            mem_resp;
  logic            pmem_read;
  logic            pmem_write;
  logic            load_lru;
  logic            wb_addr_sel;
  logic            fill_sel;
  logic [WAYS-1:0] load_data;
  logic [WAYS-1:0] load_tag;
  logic [WAYS-1:0] set_valid;
  logic [WAYS-1:0] set_dirty;
  logic [WAYS-1:0] set_clean;
  logic            multi_hit_err;
  logic [CNT_W-1:0] hit_cnt;
  logic [CNT_W-1:0] miss_cnt;
  logic [CNT_W-1:0] wb_cnt;

  modport master (
    output mem_read, mem_write, hit, valid, dirty, lru_way, pmem_resp,
    input  mem_resp, pmem_read, pmem_write, load_lru, wb_addr_sel, fill_sel,
           load_data, load_tag, set_valid, set_dirty, set_clean, multi_hit_err,
           hit_cnt, miss_cnt, wb_cnt
  );

  modport slave (
    input  mem_read, mem_write, hit, valid, dirty, lru_way, pmem_resp,
    output mem_resp, pmem_read, pmem_write, load_lru, wb_addr_sel, fill_sel,
           load_data, load_tag, set_valid, set_dirty, set_clean, multi_hit_err,
           hit_cnt, miss_cnt, wb_cnt
  );

endinterface
`default_nettype wire

// File: rtl/assoc_cache_control_perf.sv
`default_nettype none
// ============================================================================
// cache_perf_counters : wrapping hit / miss / write-back event counters
// Rev 1.0
// ============================================================================
module cache_perf_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hit_inc_i,
  input  logic             miss_inc_i,
  input  logic             wb_inc_i,
  output logic [CNT_W-1:0] hit_cnt_o,
  output logic [CNT_W-1:0] miss_cnt_o,
  output logic [CNT_W-1:0] wb_cnt_o
);

  logic [CNT_W-1:0] hit_cnt_q;
  logic [CNT_W-1:0] miss_cnt_q;
  logic [CNT_W-1:0] wb_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      if (hit_inc_i)  hit_cnt_q  <= hit_cnt_q  + CNT_W'(1);
      if (miss_inc_i) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
      if (wb_inc_i)   wb_cnt_q   <= wb_cnt_q   + CNT_W'(1);
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
  assign wb_cnt_o   = wb_cnt_q;

endmodule
`default_nettype wire

// File: rtl/assoc_cache_control.sv
`default_nettype none
// ============================================================================
// assoc_cache_control : N-way set-associative cache controller FSM
// Optional performance counters enabled by macro ASSOC_CACHE_PERF_EN.
// Rev 1.0
// ============================================================================
module assoc_cache_control
  import cache_types::*;
#(
  parameter int WAYS  = 2,
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  assoc_cache_control_if.slave bus
);

  localparam int IW = $clog2(WAYS);

  cache_state_t    state_q, state_d;
  logic [IW-1:0]   victim_q, victim_d;

  logic            w_req, w_wr, w_hit_any, w_multi, w_inv_any, w_victim_dirty;
  logic [IW-1:0]   w_hit_idx, w_inv_idx, w_victim;
  logic [WAYS-1:0] w_hit_oh, w_vq_oh;

  logic            w_mem_resp, w_pmem_read, w_pmem_write, w_load_lru;
  logic            w_wb_addr_sel, w_fill_sel, w_multi_hit_err;
  logic [WAYS-1:0] w_load_data, w_load_tag, w_set_valid, w_set_dirty, w_set_clean;

  assign w_req     = bus.mem_read | bus.mem_write;
  assign w_wr      = bus.mem_write;
  assign w_hit_any = |bus.hit;
  assign w_multi   = $countones(bus.hit) > 1;

  // Descending scans so the lowest-index candidate is the one left standing.
  always_comb begin
    w_hit_idx = '0;
    w_inv_idx = '0;
    w_inv_any = 1'b0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (bus.hit[i]) w_hit_idx = IW'(i);
      if (!bus.valid[i]) begin
        w_inv_idx = IW'(i);
        w_inv_any = 1'b1;
      end
    end
  end

  assign w_victim       = w_inv_any ? w_inv_idx : bus.lru_way;
  assign w_victim_dirty = bus.valid[w_victim] & bus.dirty[w_victim];
  assign w_hit_oh       = WAYS'(way_onehot(3'(w_hit_idx)));
  assign w_vq_oh        = WAYS'(way_onehot(3'(victim_q)));

  always_comb begin
    state_d         = state_q;
    victim_d        = victim_q;
    w_mem_resp      = 1'b0;
    w_pmem_read     = 1'b0;
    w_pmem_write    = 1'b0;
    w_load_lru      = 1'b0;
    w_wb_addr_sel   = 1'b0;
    w_fill_sel      = 1'b0;
    w_multi_hit_err = 1'b0;
    w_load_data     = '0;
    w_load_tag      = '0;
    w_set_valid     = '0;
    w_set_dirty     = '0;
    w_set_clean     = '0;
    case (state_q)
      ST_IDLE: begin
        if (w_req) state_d = ST_TAG_CHECK;
      end
      ST_TAG_CHECK: begin
        // An abandoned request (dropped during a fill) retires silently.
        if (!w_req) begin
          state_d = ST_IDLE;
        end else if (w_hit_any) begin
          w_mem_resp      = 1'b1;
          w_load_lru      = 1'b1;
          w_multi_hit_err = w_multi;
          if (w_wr) begin
            w_load_data = w_hit_oh;
            w_set_dirty = w_hit_oh;
          end
          state_d = ST_IDLE;
        end else begin
          victim_d = w_victim;
          state_d  = w_victim_dirty ? ST_WRITE_BACK : ST_ALLOCATE;
        end
      end
      ST_WRITE_BACK: begin
        w_pmem_write  = 1'b1;
        w_wb_addr_sel = 1'b1;
        if (bus.pmem_resp) begin
          w_set_clean = w_vq_oh;
          state_d     = ST_ALLOCATE;
        end
      end
      ST_ALLOCATE: begin
        w_pmem_read = 1'b1;
        w_fill_sel  = 1'b1;
        if (bus.pmem_resp) begin
          w_load_data = w_vq_oh;
          w_load_tag  = w_vq_oh;
          w_set_valid = w_vq_oh;
          w_set_clean = w_vq_oh;
          state_d     = ST_TAG_CHECK;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      victim_q <= '0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
    end
  end

  assign bus.mem_resp      = w_mem_resp;
  assign bus.pmem_read     = w_pmem_read;
  assign bus.pmem_write    = w_pmem_write;
  assign bus.load_lru      = w_load_lru;
  assign bus.wb_addr_sel   = w_wb_addr_sel;
  assign bus.fill_sel      = w_fill_sel;
  assign bus.multi_hit_err = w_multi_hit_err;
  assign bus.load_data     = w_load_data;
  assign bus.load_tag      = w_load_tag;
  assign bus.set_valid     = w_set_valid;
  assign bus.set_dirty     = w_set_dirty;
  assign bus.set_clean     = w_set_clean;

`ifdef ASSOC_CACHE_PERF_EN
  logic w_hit_inc, w_miss_inc, w_wb_inc;

  // A fill re-check with the request still held counts as a hit.
  assign w_hit_inc  = (state_q == ST_TAG_CHECK) && w_req && w_hit_any;
  assign w_miss_inc = (state_q == ST_TAG_CHECK) && w_req && !w_hit_any;
  assign w_wb_inc   = (state_q == ST_WRITE_BACK) && bus.pmem_resp;

  cache_perf_counters #(
    .CNT_W (CNT_W)
  ) u_perf (
    .clk        (clk),
    .rst_n      (rst_n),
    .hit_inc_i  (w_hit_inc),
    .miss_inc_i (w_miss_inc),
    .wb_inc_i   (w_wb_inc),
    .hit_cnt_o  (bus.hit_cnt),
    .miss_cnt_o (bus.miss_cnt),
    .wb_cnt_o   (bus.wb_cnt)
  );
`else
  assign bus.hit_cnt  = '0;
  assign bus.miss_cnt = '0;
  assign bus.wb_cnt   = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_assoc_cache_control.sv
`default_nettype none
// ============================================================================
// tb_assoc_cache_control : table, hand-written and random checks, WAYS=4
// Rev 1.0
// ============================================================================
module tb_assoc_cache_control;

  localparam int WAYS  = 4;
  localparam int CNT_W = 32;

  typedef logic [26:0] outv_t;

  typedef struct {
    logic       rd;
    logic       wr;
    logic [3:0] h;
    logic [3:0] v;
    logic [3:0] d;
    logic [1:0] lru;
    logic [3:0] way;
    logic       eh;
    logic       ewb;
    logic       emh;
    int         wlat;
    int         alat;
    logic       drop;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  assoc_cache_control_if #(.WAYS(WAYS), .CNT_W(CNT_W)) bus ();

  assoc_cache_control #(.WAYS(WAYS), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int m_hit  = 0;
  int m_miss = 0;
  int m_wb   = 0;

  function automatic outv_t mk(input logic resp, prd, pwr, llru, wbs, fil, mh,
                               input logic [3:0] ld, lt, sv, sd, sc);
    return {resp, prd, pwr, llru, wbs, fil, mh, ld, lt, sv, sd, sc};
  endfunction

  function automatic outv_t act();
    return {bus.mem_resp, bus.pmem_read, bus.pmem_write, bus.load_lru,
            bus.wb_addr_sel, bus.fill_sel, bus.multi_hit_err,
            bus.load_data, bus.load_tag, bus.set_valid, bus.set_dirty, bus.set_clean};
  endfunction

  task automatic check_out(input string nm, input outv_t exp);
    outv_t a;
    a = act();
    checks++;
    if (a !== exp) begin
      errors++;
      $display("FAIL %s: outputs got %h expected %h", nm, a, exp);
    end
  endtask

  task automatic check_cnt(input string nm);
    logic [3*CNT_W-1:0] exp, got;
`ifdef ASSOC_CACHE_PERF_EN
    exp = {CNT_W'(m_hit), CNT_W'(m_miss), CNT_W'(m_wb)};
`else
    exp = '0;
`endif
    got = {bus.hit_cnt, bus.miss_cnt, bus.wb_cnt};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: counters hit/miss/wb got %0d/%0d/%0d expected %0d/%0d/%0d", nm,
               got[3*CNT_W-1:2*CNT_W], got[2*CNT_W-1:CNT_W], got[CNT_W-1:0],
               exp[3*CNT_W-1:2*CNT_W], exp[2*CNT_W-1:CNT_W], exp[CNT_W-1:0]);
    end
  endtask

  // Reference decision from the rules: lowest hit way, else lowest invalid, else LRU.
  task automatic ref_decide(inout vec_t t);
    int vi;
    t.eh  = (t.h != 4'b0);
    t.emh = ($countones(t.h) > 1);
    t.way = 4'b0;
    t.ewb = 1'b0;
    if (t.eh) begin
      for (int i = 3; i >= 0; i--) if (t.h[i]) t.way = 4'(1 << i);
    end else begin
      vi = int'(t.lru);
      for (int i = 3; i >= 0; i--) if (!t.v[i]) vi = i;
      t.way = 4'(1 << vi);
      t.ewb = t.v[vi] & t.d[vi];
    end
  endtask

  task automatic run_txn(input vec_t t, input string nm);
    logic [3:0] wd;
    wd = t.wr ? t.way : 4'b0;
    @(negedge clk);
    bus.mem_read = t.rd; bus.mem_write = t.wr;
    bus.hit = t.h; bus.valid = t.v; bus.dirty = t.d; bus.lru_way = t.lru;
    bus.pmem_resp = 1'($urandom_range(0, 1));
    #1 check_out({nm, "/idle"}, '0);
    @(negedge clk);
    bus.pmem_resp = 1'($urandom_range(0, 1));
    #1;
    if (t.eh) begin
      check_out({nm, "/hit"}, mk(1, 0, 0, 1, 0, 0, t.emh, wd, 0, 0, wd, 0));
      m_hit++;
    end else begin
      check_out({nm, "/miss"}, '0);
      m_miss++;
      if (t.ewb) begin
        for (int i = 0; i <= t.wlat; i++) begin
          @(negedge clk);
          bus.pmem_resp = (i == t.wlat);
          #1 check_out({nm, "/wb"}, mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0,
                                       (i == t.wlat) ? t.way : 4'b0));
        end
        m_wb++;
      end
      for (int i = 0; i <= t.alat; i++) begin
        logic [3:0] f;
        @(negedge clk);
        bus.pmem_resp = (i == t.alat);
        if (t.drop && i == 0) begin
          bus.mem_read = 1'b0; bus.mem_write = 1'b0;
        end
        f = (i == t.alat) ? t.way : 4'b0;
        #1 check_out({nm, "/alloc"}, mk(0, 1, 0, 0, 0, 1, 0, f, f, f, 0, f));
      end
      @(negedge clk);
      bus.pmem_resp = 1'($urandom_range(0, 1));
      bus.hit   = t.way;
      bus.valid = bus.valid | t.way;
      #1;
      if (t.drop) check_out({nm, "/drop"}, '0);
      else begin
        check_out({nm, "/recheck"}, mk(1, 0, 0, 1, 0, 0, 0, wd, 0, 0, wd, 0));
        m_hit++;
      end
    end
    bus.mem_read = 1'b0; bus.mem_write = 1'b0;
    @(negedge clk);
    bus.pmem_resp = 1'b0;
    #1 check_out({nm, "/done"}, '0);
    check_cnt({nm, "/cnt"});
  endtask

  vec_t tbl[11];

  initial begin
    vec_t r;
    bus.mem_read = 0; bus.mem_write = 0; bus.hit = 0; bus.valid = 0;
    bus.dirty = 0; bus.lru_way = 0; bus.pmem_resp = 0;

    //                 rd wr  h        v        d        lru  way     eh ewb emh wl al drop
    tbl[0]  = '{1, 0, 4'b0100, 4'b1111, 4'b0000, 2'd0, 4'b0100, 1, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 1, 4'b0000, 4'b1111, 4'b0010, 2'd1, 4'b0010, 0, 1, 0, 2, 3, 0};
    tbl[2]  = '{1, 0, 4'b0000, 4'b1011, 4'b1111, 2'd0, 4'b0100, 0, 0, 0, 0, 1, 0};
    tbl[3]  = '{1, 0, 4'b0110, 4'b1111, 4'b0000, 2'd3, 4'b0010, 1, 0, 1, 0, 0, 0};
    tbl[4]  = '{0, 1, 4'b1000, 4'b1111, 4'b0000, 2'd0, 4'b1000, 1, 0, 0, 0, 0, 0};
    tbl[5]  = '{1, 1, 4'b0001, 4'b1111, 4'b0000, 2'd2, 4'b0001, 1, 0, 0, 0, 0, 0};
    tbl[6]  = '{1, 0, 4'b0000, 4'b1111, 4'b0000, 2'd3, 4'b1000, 0, 0, 0, 0, 0, 0};
    tbl[7]  = '{1, 0, 4'b0000, 4'b1111, 4'b1000, 2'd3, 4'b1000, 0, 1, 0, 0, 0, 0};
    tbl[8]  = '{1, 0, 4'b0000, 4'b0111, 4'b0000, 2'd1, 4'b1000, 0, 0, 0, 0, 2, 1};
    tbl[9]  = '{0, 1, 4'b1111, 4'b1111, 4'b1111, 2'd0, 4'b0001, 1, 0, 1, 0, 0, 0};
    tbl[10] = '{1, 0, 4'b0000, 4'b0000, 4'b1111, 2'd2, 4'b0001, 0, 0, 0, 0, 1, 0};

    #3;
    check_out("reset_outputs", '0);
    check_cnt("reset_counters");
    @(negedge clk);
    rst_n = 1'b1;

    // Stray pmem_resp with no request must not move the FSM.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.pmem_resp = 1'b1;
      #1 check_out($sformatf("idle_stray_resp%0d", i), '0);
    end

    for (int i = 0; i < 11; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    // Asynchronous reset during ALLOCATE, then immediate restart.
    @(negedge clk);
    bus.mem_read = 1; bus.mem_write = 0; bus.hit = 0; bus.valid = 4'b1111;
    bus.dirty = 0; bus.lru_way = 2'd2; bus.pmem_resp = 0;
    @(negedge clk);
    @(negedge clk);
    #1 check_out("rst_pre_alloc", mk(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    #2 rst_n = 1'b0;
    #1 check_out("rst_async_outputs", '0);
    m_hit = 0; m_miss = 0; m_wb = 0;
    check_cnt("rst_async_counters");
    @(negedge clk);
    bus.hit = 4'b0001;
    #1 check_out("rst_held", '0);
    rst_n = 1'b1;
    @(negedge clk);
    #1 check_out("rst_first_edge", mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    m_hit++;
    bus.mem_read = 0;
    @(negedge clk);
    #1 check_out("rst_idle", '0);
    check_cnt("rst_cnt");

    for (int n = 0; n < 40; n++) begin
      r.wr   = 1'($urandom_range(0, 1));
      r.rd   = r.wr ? 1'($urandom_range(0, 1)) : 1'b1;
      r.h    = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'b0;
      r.v    = 4'($urandom);
      r.d    = 4'($urandom);
      r.lru  = 2'($urandom);
      r.wlat = $urandom_range(0, 3);
      r.alat = $urandom_range(0, 3);
      r.drop = ($urandom_range(0, 7) == 0);
      ref_decide(r);
      run_txn(r, $sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/assoc_cache_control.md
ASSOC_CACHE_CONTROL -- requirements
Module: assoc_cache_control

Interface
REQ-001 SHALL have parameter WAYS, default 2, number of ways (power of two, 2..8).
REQ-002 SHALL have parameter CNT_W, default 32, width of each performance counter.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports mem_read, mem_write  input  1 each  CPU request strobes, held until mem_resp.
REQ-006 SHALL have ports hit, valid, dirty  input  WAYS each  per-way status for the addressed set.
REQ-007 SHALL have port lru_way  input  $clog2(WAYS)  replacement candidate from the datapath.
REQ-008 SHALL have port pmem_resp  input  1  physical memory completion.
REQ-009 SHALL have ports mem_resp, pmem_read, pmem_write, load_lru, wb_addr_sel, fill_sel  output  1 each.
REQ-010 SHALL have ports load_data, load_tag, set_valid, set_dirty, set_clean  output  WAYS each  one-hot way strobes.
REQ-011 SHALL have port multi_hit_err  output  1  more than one hit bit set in TAG_CHECK.
REQ-012 SHALL have ports hit_cnt, miss_cnt, wb_cnt  output  CNT_W each  performance counters.

Function
REQ-013 SHALL implement states IDLE, TAG_CHECK, WRITE_BACK, ALLOCATE; all outputs default 0 in every state.
REQ-014 IDLE: mem_read|mem_write -> TAG_CHECK next cycle; otherwise stay.
REQ-015 TAG_CHECK hit (|hit): mem_resp=1 and load_lru=1 same cycle; write also drives load_data[w], set_dirty[w]; -> IDLE.
REQ-016 Hit way w SHALL be the lowest-index set hit bit; multi_hit_err=1 for that cycle if popcount(hit)>1.
REQ-017 TAG_CHECK miss: victim = lowest-index invalid way, else lru_way; victim registered in victim_q.
REQ-018 Miss with valid[victim] & dirty[victim] -> WRITE_BACK; otherwise -> ALLOCATE.
REQ-019 WRITE_BACK: pmem_write=1, wb_addr_sel=1 each cycle; on pmem_resp set_clean[victim_q]=1 -> ALLOCATE.
REQ-020 ALLOCATE: pmem_read=1, fill_sel=1; on pmem_resp load_data, load_tag, set_valid, set_clean on victim_q -> TAG_CHECK.
REQ-021 Hit latency SHALL be 2 cycles from request; clean miss 2+N+1 (N = pmem latency).
REQ-022 mem_read and mem_write both high SHALL be treated as a write.
REQ-023 Request deasserted mid-miss: SHALL complete fill, return to TAG_CHECK, then IDLE with no mem_resp.
REQ-024 pmem_resp outside WRITE_BACK/ALLOCATE SHALL be ignored.
REQ-025 hit_cnt/miss_cnt increment once per TAG_CHECK hit/miss (post-fill re-check counts as hit); wb_cnt once per WRITE_BACK exit; all wrap at 2^CNT_W.

Reset
REQ-026 rst_n low SHALL force IDLE, victim_q=0, counters=0 asynchronously; all outputs 0 immediately, including mid-transaction pmem_read/pmem_write.
REQ-027 First transition after rst_n release SHALL occur on the first clk edge with rst_n high.

Configuration
REQ-028 Macro ASSOC_CACHE_PERF_EN defined: counters per REQ-025; undefined: hit_cnt, miss_cnt, wb_cnt tied 0, no counter flops.

Structure
REQ-029 State enum cache_state_t and one-hot helper function SHALL reside in shared package cache_types.
REQ-030 Counters SHALL be sub-module cache_perf_counters, instantiated only under ASSOC_CACHE_PERF_EN.

Verification
REQ-031 WAYS=4, read, hit=4'b0100 -> mem_resp, load_lru at cycle 2; no strobes; hit_cnt=1.
REQ-032 Write, hit=0, valid=4'b1111, dirty=4'b0010, lru_way=1 -> WRITE_BACK, set_clean=4'b0010, ALLOCATE, load_data=4'b0010, re-check hit -> mem_resp; wb_cnt=1, miss_cnt=1.
REQ-033 Read miss, valid=4'b1011 -> victim way 2 regardless of lru_way; straight to ALLOCATE.
REQ-034 hit=4'b0110 -> way 1 chosen, multi_hit_err pulses one cycle.
REQ-035 rst_n low during ALLOCATE with pmem_read=1 -> pmem_read 0 without clock edge; IDLE after release; counters 0.
REQ-036 Build without ASSOC_CACHE_PERF_EN, repeat REQ-032 -> all counters read 0, behaviour otherwise identical.
